// File: rtl/p1c1_pkg.sv
// p1c1_pkg: driver FSM states and the p1c1 next-state/output functions shared by models of the circuit.
package p1c1_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

   // State is packed {d, e}.
   function automatic logic [1:0] p1c1_next_state(input logic in, input logic [1:0] s);
      logic se_n;
      se_n = in ^ s[0];
      return {~(~(in & s[1]) & se_n), se_n};
   endfunction

   function automatic logic p1c1_out(input logic [1:0] s);
      return ~(s[1] | s[0]);
   endfunction

endpackage

// File: rtl/p1c1_shadow.sv
// p1c1_shadow: cycle-accurate 2-bit shadow of p1c1, stepping on every edge from the same drive as the real circuit.
module p1c1_shadow
   import p1c1_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic sd,
   output logic se,
   output logic exp_out
);

   logic [1:0] s;

   always_ff @(posedge clk or posedge reset)
      if (reset) s <= 2'b00;
      else       s <= p1c1_next_state(in, s);

   assign {sd, se} = s;
   assign exp_out  = p1c1_out(s);

endmodule

// File: rtl/p1c1_driver.sv
// p1c1_driver: serialises stimulus words LSB-first into p1c1 and checks it against a shadow model.
// Define P1C1_DRIVER_STATE_CHECK_EN to also compare d/e; otherwise only out is checked.
module p1c1_driver
   import p1c1_pkg::*;
#(
   parameter int WORD_W    = 8,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 word_valid,
   input  logic [WORD_W-1:0]    word_data,
   output logic                 word_ready,
   output logic                 dut_in,
   input  logic                 dut_out,
   input  logic                 dut_d,
   input  logic                 dut_e,
   input  logic                 err_clear,
   output logic                 busy,
   output logic                 done,
   output logic                 done_mismatch,
   output logic [WORD_W-1:0]    mismatch_bits,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 sticky_err
);

   localparam int KW = $clog2(WORD_W);

   state_t              state, state_n;
   logic [KW-1:0]       k;
   logic [WORD_W-1:0]   sreg;
   logic [WORD_W-2:0]   mask;
   logic [WORD_W-1:0]   final_mask;
   logic                sd, se, exp_out, mismatch, accept, last;

   p1c1_shadow u_shadow (
      .clk     (clk),
      .reset   (reset),
      .in      (dut_in),
      .sd      (sd),
      .se      (se),
      .exp_out (exp_out)
   );

`ifdef P1C1_DRIVER_STATE_CHECK_EN
   assign mismatch = (dut_d != sd) | (dut_e != se) | (dut_out != exp_out);
`else
   logic unused_state;
   assign unused_state = dut_d ^ dut_e ^ sd ^ se;
   assign mismatch     = dut_out != exp_out;
`endif

   assign word_ready = state == IDLE;
   assign busy       = state != IDLE;
   assign accept     = word_valid & word_ready;
   assign last       = k == KW'(WORD_W - 1);
   // The CHECK cycle contributes the final bit directly, so the working mask holds only bits 0..WORD_W-2.
   assign final_mask = {mismatch, mask};

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = word_valid ? SHIFT : IDLE;
         SHIFT:   state_n = last ? CHECK : SHIFT;
         CHECK:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         dut_in        <= 1'b0;
         sreg          <= '0;
         mask          <= '0;
         k             <= '0;
         done          <= 1'b0;
         done_mismatch <= 1'b0;
         mismatch_bits <= '0;
         err_count     <= '0;
         sticky_err    <= 1'b0;
      end else begin
         done <= state == CHECK;
         if (accept) begin
            sreg   <= word_data >> 1;
            dut_in <= word_data[0];
            mask   <= '0;
            k      <= '0;
         end else if (state == SHIFT) begin
            if (k != '0) mask[k - 1'b1] <= mismatch;
            dut_in <= last ? 1'b0 : sreg[0];
            sreg   <= sreg >> 1;
            k      <= k + 1'b1;
         end
         if (state == CHECK) begin
            mismatch_bits <= final_mask;
            done_mismatch <= |final_mask;
         end
         if (err_clear) begin
            err_count  <= '0;
            sticky_err <= 1'b0;
         end else if (state == CHECK && |final_mask) begin
            err_count  <= &err_count ? err_count : err_count + 1'b1;
            sticky_err <= 1'b1;
         end
      end

endmodule

// File: doc/p1c1_driver.md
# p1c1_driver

Stimulus-and-check driver for the two-flip-flop `p1c1` sequential circuit. Accepts stimulus words over a valid/ready handshake, serialises each word LSB-first onto the circuit's `in` input, and runs a cycle-accurate shadow model of the circuit's next-state logic. It compares the circuit's `d`/`e`/`out` against the shadow model and reports a per-word mismatch mask, a done pulse and a saturating error count. It sits on the input side of `p1c1`, shares its clock and reset, and consumes its outputs.

## Interface
- `WORD_W`, default 8: stimulus bits per word (≥2).
- `ERR_CNT_W`, default 8: width of the mismatched-word counter.

- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  reset, asynchronous, active-high (same net as the `p1c1` reset).
- `word_valid`  in  1  stimulus word offered.
- `word_data`  in  WORD_W  stimulus word; bit 0 is applied first.
- `word_ready`  out  1  driver can accept a word.
- `dut_in`  out  1  registered drive to `p1c1.in`.
- `dut_out`, `dut_d`, `dut_e`  in  1 each  `p1c1` outputs `out`, `d`, `e`.
- `err_clear`  in  1  synchronous clear of `err_count` and `sticky_err`.
- `busy`  out  1  word in progress.
- `done`  out  1  one-cycle pulse: word finished.
- `done_mismatch`  out  1  valid with `done`; equals OR of `mismatch_bits`.
- `mismatch_bits`  out  WORD_W  bit k set means the state after applying bit k mismatched; held until next `done`.
- `err_count`  out  ERR_CNT_W  number of words with a mismatch; saturates at all-ones.
- `sticky_err`  out  1  set on any mismatched word; cleared only by reset or `err_clear`.

## Operation
- Shadow model: state `(sd,se)`, reset `00`.
  - Every clock edge, regardless of FSM state: `se' = dut_in ^ se`, `sd' = ~(~(dut_in & sd) & se')`.
  - Expected out is `~(sd | se)`.
  - Transitions (in=0 / in=1): `00→10/01`, `01→01/10`, `10→10/11`, `11→01/10`.
- Compare: mismatch = `dut_d≠sd` or `dut_e≠se` or `dut_out≠~(sd|se)` (see Configuration).
- FSM states:
  - IDLE: `word_ready=1`, `dut_in=0`. On `word_valid & word_ready`, latch `word_data` into the shift register, load `dut_in <= word_data[0]`, clear the working mask, set bit counter k=0, and go to SHIFT.
  - SHIFT: lasts WORD_W cycles.
    - In cycles with k≥1, the compare result is written to working mask bit k−1.
    - At each edge, shift the next bit onto `dut_in` and increment k.
    - After bit WORD_W−1 has been presented, drive `dut_in <= 0` and go to CHECK.
  - CHECK: one cycle. The compare result is written to mask bit WORD_W−1, then go to IDLE.
    - At that edge: pulse `done`, update `mismatch_bits` and `done_mismatch`, increment `err_count` (saturating) and set `sticky_err` if any mask bit is set.
- `busy=1` in SHIFT and CHECK.
- `word_ready` is `state==IDLE` (combinational). Back-to-back acceptance is legal in the same cycle `done` is high.
- `err_clear` coinciding with an increment: clear wins; the counter reads 0.

## Timing
- Reset values:
  - FSM=IDLE, `dut_in=0`, shadow `00`, `busy=0`, `done=0`, `done_mismatch=0`, `mismatch_bits=0`, `err_count=0`, `sticky_err=0`.
  - `word_ready` reads 1; no transfer is taken while `reset` is high.
- Latency: accept edge T0; bit k is on `dut_in` during cycles T0+k..T0+k+1; `done` is high in the cycle after edge T0+WORD_W+1.
- Throughput: one word per WORD_W+2 cycles.
- Reset mid-word: immediate return to IDLE. The partial mask is discarded and no `done` is generated. The shadow returns to `00` in lockstep with `p1c1`.
- Idle cycles still step the shadow with `in=0`. From reset the pair settles to `10`.

## Configuration
- `P1C1_DRIVER_STATE_CHECK_EN` defined: compare `dut_d`, `dut_e` and `dut_out`.
- Undefined: compare `dut_out` only (black-box check). `dut_d`/`dut_e` are ignored.

## Structure
- Shared package `p1c1_pkg`: FSM state enum (`IDLE`, `SHIFT`, `CHECK`), and the `p1c1_next_state` and `p1c1_out` functions. These functions are shared with any future `p1c1` model.
- Sub-module `p1c1_shadow`: the 2-bit shadow register plus expected outputs. The FSM, shift register, mask and counters stay in `p1c1_driver`.

## Test plan
- Reset, 5 idle cycles, then word 0x05 with a correct `p1c1` → `done` at T0+WORD_W+2, `done_mismatch=0`, `mismatch_bits=0x00`, `err_count=0`.
- `dut_e` forced to 0, word 0x01 after idle (shadow `10`) → `mismatch_bits=0xFF`, `done_mismatch=1`, `err_count=1`, `sticky_err=1`.
- Back-to-back: `word_valid` held high with 0xA5 then 0x3C → second accept in the `done` cycle, two `done` pulses 10 cycles apart, no bubbles.
- `err_count` saturation: with `ERR_CNT_W=2`, send 5 faulty words → count 1,2,3,3,3. `err_clear` asserted on a faulty word's `done` edge → count 0, `sticky_err=0`.
- `reset` asserted at k=3 of word 0xFF → `dut_in=0`, `busy=0`, no `done`, shadow `00`. The next word 0x01 passes with no mismatch.
- Build without `P1C1_DRIVER_STATE_CHECK_EN` and `dut_d` forced to 1 → no mismatch. Forcing `dut_out` to 1 in state `10` → mismatch bits set.
